mips_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the execute stage, alongside the ALU. It takes the same SrcA/SrcB operands and implements MULT/MULTU/DIV/DIVU into architectural HI/LO registers. HI/LO are read back through the writeback result mux for MFHI/MFLO. Busy drives the pipeline stall logic.

---
 rtl/mips_muldiv_pkg.sv | 20 ++
 rtl/mips_muldiv_signfix.sv | 35 +++
 rtl/mips_muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

    // Default iteration count: one radix-2 step per operand bit.
    localparam int MD_ITER = 32;

    // Op field as presented by the decoder.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mips_muldiv_signfix.sv
// Sign helper: conditionally negates two WIDTH-bit values independently,
// or, when wide=1, the concatenated 2*WIDTH-bit pair {hi,lo} as one number
// (neg_hi then controls the whole pair).
module mips_muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic             wide,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             neg_hi,
    input  logic             neg_lo,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [2*WIDTH-1:0] pair;
    logic [2*WIDTH-1:0] pair_neg;

    // Two's complement negation, either per half or across the full pair.
    always_comb begin
        pair     = {hi_in, lo_in};
        pair_neg = '0 - pair;
        hi_out   = hi_in;
        lo_out   = lo_in;
        if (wide) begin
            if (neg_hi) begin
                {hi_out, lo_out} = pair_neg;
            end
        end else begin
            if (neg_hi) hi_out = '0 - hi_in;
            if (neg_lo) lo_out = '0 - lo_in;
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Magnitudes are iterated unsigned; signs are reapplied in the FIX state.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = MD_ITER
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HIWrite,
    input  logic             LOWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = $clog2(ITER + 1);

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic               accept;

    logic [1:0]         op_r;
    logic [WIDTH-1:0]   dv_r;        // addend (multiply) or divisor (divide)
    logic [WIDTH-1:0]   orig_a_r;    // raw dividend, returned in HI on divide-by-zero
    logic               sign_a_r;
    logic               sign_b_r;
    logic               bzero_r;
    logic [2*WIDTH-1:0] acc;

    logic               in_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;

    logic               r_div, r_signed, divz;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   fx_hi, fx_lo;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign accept    = Start && (state == ST_IDLE || state == ST_DONE);
    assign Busy      = (state == ST_CALC) || (state == ST_FIX);
    assign Done      = (state == ST_DONE);
    assign in_signed = (Op == OP_MULT) || (Op == OP_DIV);

    // Operand magnitudes on entry.
    mips_muldiv_signfix #(.WIDTH(WIDTH)) u_entry (
        .wide   (1'b0),
        .hi_in  (SrcA),
        .lo_in  (SrcB),
        .neg_hi (in_signed & SrcA[WIDTH-1]),
        .neg_lo (in_signed & SrcB[WIDTH-1]),
        .hi_out (abs_a),
        .lo_out (abs_b)
    );

    assign r_div    = (op_r == OP_DIV) || (op_r == OP_DIVU);
    assign r_signed = (op_r == OP_MULT) || (op_r == OP_DIV);
    assign divz     = r_div & bzero_r;

    // Sign correction of the finished magnitude result. Multiply negates the
    // full 2*WIDTH product; divide negates quotient and remainder separately,
    // the remainder following the dividend's sign.
    mips_muldiv_signfix #(.WIDTH(WIDTH)) u_fix (
        .wide   (~r_div),
        .hi_in  (acc[2*WIDTH-1:WIDTH]),
        .lo_in  (acc[WIDTH-1:0]),
        .neg_hi (r_signed & (r_div ? sign_a_r : (sign_a_r ^ sign_b_r))),
        .neg_lo (r_signed & (sign_a_r ^ sign_b_r)),
        .hi_out (fx_hi),
        .lo_out (fx_lo)
    );

    // One radix-2 iteration: shift-add multiply or restoring divide.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dv_r} : '0);
        div_rem  = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_rem - {1'b0, dv_r};
        acc_step = {mul_sum, acc[WIDTH-1:1]};
        if (r_div) begin
            if (div_diff[WIDTH]) acc_step = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else                 acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
        fix_hi = divz ? orig_a_r : fx_hi;
        fix_lo = divz ? '1       : fx_lo;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (Start) state_nx = ST_CALC;
            ST_CALC: if (cnt == CW'(ITER - 1)) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: state_nx = Start ? ST_CALC : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State and iteration counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept)                cnt <= '0;
            else if (state == ST_CALC) cnt <= cnt + CW'(1);
        end
    end

    // Operand capture at launch and accumulator iteration (datapath, no reset).
    always_ff @(posedge CLK) begin
        if (accept) begin
            op_r     <= Op;
            orig_a_r <= SrcA;
            sign_a_r <= in_signed & SrcA[WIDTH-1];
            sign_b_r <= in_signed & SrcB[WIDTH-1];
            bzero_r  <= (SrcB == '0);
            if (Op == OP_DIV || Op == OP_DIVU) begin
                dv_r <= abs_b;
                acc  <= {{WIDTH{1'b0}}, abs_a};
            end else begin
                dv_r <= abs_a;
                acc  <= {{WIDTH{1'b0}}, abs_b};
            end
        end else if (state == ST_CALC) begin
            acc <= acc_step;
        end
    end

    // Architectural HI/LO: result write in FIX, MTHI/MTLO only when not busy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            HI <= '0;
            LO <= '0;
        end else if (state == ST_FIX) begin
            HI <= fix_hi;
            LO <= fix_lo;
        end else if (!Busy) begin
            if (HIWrite) HI <= WriteData;
            if (LOWrite) LO <= WriteData;
        end
    end

    // Divide-by-zero flag, held through DONE and cleared on the next launch.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                  DivZero <= 1'b0;
        else if (accept)           DivZero <= 1'b0;
        else if (state == ST_FIX)  DivZero <= divz;
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit with an arithmetic reference model.
module tb_mips_muldiv_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         Start = 1'b0;
    logic [1:0]   Op = 2'b00;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         HIWrite = 1'b0;
    logic         LOWrite = 1'b0;
    logic [W-1:0] WriteData = '0;
    logic [W-1:0] HI, LO;
    logic         Busy, Done, DivZero;

    int checks = 0;
    int errors = 0;

    mips_muldiv_unit #(.WIDTH(W), .ITER(32)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
        .HIWrite(HIWrite), .LOWrite(LOWrite), .WriteData(WriteData),
        .HI(HI), .LO(LO), .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic signed [63:0] sa, sb, sr;
        logic [63:0] ua, ub, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin sr = sa * sb; hi = sr[63:32]; lo = sr[31:0]; end
            2'b01: begin ur = ua * ub; hi = ur[63:32]; lo = ur[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFFFFFF; dz = 1'b1;
                end else if (op == 2'b10) begin
                    sr = sa / sb; lo = sr[31:0];
                    sr = sa % sb; hi = sr[31:0];
                end else begin
                    ur = ua / ub; lo = ur[31:0];
                    ur = ua % ub; hi = ur[31:0];
                end
            end
        endcase
    endfunction

    // Launch one operation, scramble inputs after launch, check timing and result.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic edz;
        int n, busy_n;
        model(op, a, b, eh, el, edz);
        Op = op; SrcA = a; SrcB = b; Start = 1'b1;
        tick();
        Start = 1'b0;
        Op = 2'($urandom); SrcA = $urandom; SrcB = $urandom;
        n = 1;
        busy_n = Busy ? 1 : 0;
        checks++;
        if (DivZero !== 1'b0) begin
            errors++; $display("FAIL %s divzero_clear got %b want 0", name, DivZero);
        end
        while (!Done && n < 100) begin
            tick();
            n++;
            if (Busy) busy_n++;
        end
        checks++;
        if (n !== 34) begin
            errors++; $display("FAIL %s latency got %0d want 34", name, n);
        end
        checks++;
        if (busy_n !== 33) begin
            errors++; $display("FAIL %s busy_cycles got %0d want 33", name, busy_n);
        end
        checks++;
        if (HI !== eh || LO !== el) begin
            errors++; $display("FAIL %s hi_lo got %h_%h want %h_%h", name, HI, LO, eh, el);
        end
        checks++;
        if (DivZero !== edz) begin
            errors++; $display("FAIL %s divzero got %b want %b", name, DivZero, edz);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #1;
        checks++;
        if (HI !== 0 || LO !== 0 || Busy !== 0 || Done !== 0 || DivZero !== 0) begin
            errors++;
            $display("FAIL reset got hi=%h lo=%h busy=%b done=%b dz=%b want all 0", HI, LO, Busy, Done, DivZero);
        end
        repeat (2) tick();
        @(negedge CLK);
        RST = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        run_op("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'd7);
        checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB) begin
            errors++; $display("FAIL mult_const got %h_%h want ffffffff_ffffffeb", HI, LO);
        end
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++;
        if (HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
            errors++; $display("FAIL multu_const got %h_%h want fffffffe_00000001", HI, LO);
        end
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7);
        checks++;
        if (HI !== 32'd2 || LO !== 32'd14) begin
            errors++; $display("FAIL divu_const got %0d_%0d want 2_14", HI, LO);
        end
        run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2);
        checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL div_const got %h_%h want ffffffff_fffffffd", HI, LO);
        end
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF);
        checks++;
        if (HI !== 32'h0 || LO !== 32'h80000000) begin
            errors++; $display("FAIL div_ovf_const got %h_%h want 00000000_80000000", HI, LO);
        end
        run_op("divu_zero", 2'b11, 32'h1234, 32'h0);
        checks++;
        if (HI !== 32'h1234 || LO !== 32'hFFFFFFFF || DivZero !== 1'b1) begin
            errors++; $display("FAIL divz_const got %h_%h dz=%b want 00001234_ffffffff dz=1", HI, LO, DivZero);
        end
        run_op("div_zero_signed", 2'b10, 32'hFFFFFF00, 32'h0);
    endtask

    task automatic test_back_to_back();
        // Each call launches in the DONE cycle of the previous one.
        run_op("b2b_0", 2'b01, 32'd12345, 32'd678);
        run_op("b2b_1", 2'b10, 32'h80000001, 32'd3);
        run_op("b2b_2", 2'b00, 32'h7FFFFFFF, 32'h80000000);
        tick();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse got done=%b busy=%b want 0 0", Done, Busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            logic [31:0] a, b;
            op = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFFFFFF - $urandom_range(0, 3);
                3: a = $urandom_range(0, 100);
                default: ;
            endcase
            run_op("random", op, a, b);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] hi_before;
        int n;
        Op = 2'b00; SrcA = 32'd5; SrcB = 32'd6; Start = 1'b1;
        tick();
        Start = 1'b0;
        n = 1;
        hi_before = HI;
        while (!Done && n < 100) begin
            if (n == 10) begin Start = 1'b1; Op = 2'b11; SrcA = 32'd99; SrcB = 32'd4; end
            if (n == 12) begin HIWrite = 1'b1; WriteData = 32'hAAAA; end
            tick();
            n++;
            if (n == 11) Start = 1'b0;
            if (n == 13) begin
                HIWrite = 1'b0;
                checks++;
                if (HI !== hi_before) begin
                    errors++; $display("FAIL busy_mthi got %h want %h", HI, hi_before);
                end
            end
        end
        checks++;
        if (n !== 34) begin
            errors++; $display("FAIL busy_ignore_latency got %0d want 34", n);
        end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd30) begin
            errors++; $display("FAIL busy_ignore_result got %h_%h want 00000000_0000001e", HI, LO);
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] hi_before;
        tick();
        hi_before = HI;
        LOWrite = 1'b1; WriteData = 32'h55;
        tick();
        LOWrite = 1'b0;
        checks++;
        if (LO !== 32'h55 || HI !== hi_before) begin
            errors++; $display("FAIL mtlo got %h_%h want %h_00000055", HI, LO, hi_before);
        end
        HIWrite = 1'b1; WriteData = 32'hC0FFEE;
        tick();
        HIWrite = 1'b0;
        checks++;
        if (HI !== 32'hC0FFEE || LO !== 32'h55) begin
            errors++; $display("FAIL mthi got %h_%h want 00c0ffee_00000055", HI, LO);
        end
        // Write and launch on the same edge: write lands, completion overwrites.
        HIWrite = 1'b1; WriteData = 32'h1111; Op = 2'b01; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1;
        tick();
        HIWrite = 1'b0; Start = 1'b0;
        checks++;
        if (HI !== 32'h1111 || Busy !== 1'b1) begin
            errors++; $display("FAIL same_edge got hi=%h busy=%b want 00001111 1", HI, Busy);
        end
        for (int k = 0; k < 100 && !Done; k++) tick();
        checks++;
        if (Done !== 1'b1 || HI !== 32'd0 || LO !== 32'd81) begin
            errors++; $display("FAIL same_edge_result got done=%b %h_%h want 1 00000000_00000051", Done, HI, LO);
        end
    endtask

    task automatic test_reset_mid();
        Op = 2'b10; SrcA = 32'hFFFFFF9C; SrcB = 32'd7; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (14) tick();
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (HI !== 0 || LO !== 0 || Busy !== 0 || Done !== 0 || DivZero !== 0) begin
            errors++;
            $display("FAIL reset_mid got hi=%h lo=%h busy=%b done=%b dz=%b want all 0", HI, LO, Busy, Done, DivZero);
        end
        repeat (2) tick();
        checks++;
        if (Busy !== 0 || Done !== 0) begin
            errors++; $display("FAIL reset_hold got busy=%b done=%b want 0 0", Busy, Done);
        end
        @(negedge CLK);
        RST = 1'b1;
        run_op("after_reset", 2'b10, 32'hFFFFFF9C, 32'd7);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_ignore();
        test_mthi_mtlo();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
